// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants and helpers: S-box, bit permutation index,
// key-schedule step and round-key addition.
package present_pkg;

    localparam int N_B = 64;
    localparam int N_K = 80;
    localparam int N_R = 32;

    // Nibble i of this constant is S(i): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic int perm_idx(input int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

    function automatic logic [N_K-1:0] key_schedule(input logic [N_K-1:0] kr,
                                                    input logic [4:0]     rc);
        logic [N_K-1:0] t;
        t          = {kr[18:0], kr[79:19]};
        t[79:76]   = sbox4(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [N_B-1:0] add_round_key(input logic [N_B-1:0] s,
                                                     input logic [N_K-1:0] kr);
        return s ^ kr[79:16];
    endfunction

endpackage

// File: rtl/present_round_comb.sv
// One combinational PRESENT round: key XOR, 16 parallel S-boxes, bit permutation.
module present_round_comb
    import present_pkg::*;
(
    input  logic [N_B-1:0] i_state,
    input  logic [N_B-1:0] i_rk,
    output logic [N_B-1:0] o_state
);

    logic [N_B-1:0] w_sub;

    genvar gi;
    generate
        for (gi = 0; gi < N_B / 4; gi++) begin : g_sbox
            assign w_sub[4*gi +: 4] = sbox4(i_state[4*gi +: 4] ^ i_rk[4*gi +: 4]);
        end
        for (gi = 0; gi < N_B; gi++) begin : g_perm
            localparam int P = perm_idx(gi);
            assign o_state[P] = w_sub[gi];
        end
    endgenerate

endmodule

// File: rtl/present80_encrypt_core.sv
// Iterative PRESENT-80 encryptor: one round per clock, 31 rounds, then the
// final whitening key folded into the last round edge.
module present80_encrypt_core
    import present_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [N_B-1:0] i_m,
    input  logic [N_K-1:0] i_k,
    output logic [N_B-1:0] o_c,
    output logic           o_busy,
    output logic           o_done
);

    state_e         r_fsm;
    state_e         w_fsm_nxt;
    logic [N_B-1:0] r_state;
    logic [N_K-1:0] r_key;
    logic [4:0]     r_rc;
    logic [N_B-1:0] r_c;
    logic           r_done;

    logic [N_B-1:0] w_round;
    logic [N_K-1:0] w_key_nxt;
    logic           w_last;

    present_round_comb u_round (
        .i_state (r_state),
        .i_rk    (r_key[79:16]),
        .o_state (w_round)
    );

    assign w_key_nxt = key_schedule(r_key, r_rc);
    assign w_last    = (r_rc == 5'(N_R - 1));

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (i_start) w_fsm_nxt = S_RUN;
            S_RUN:   if (w_last)  w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_rc    <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= i_m;
                        r_key   <= i_k;
                        r_rc    <= 5'd1;
                    end
                end
                S_RUN: begin
                    r_state <= w_round;
                    r_key   <= w_key_nxt;
                    // Last edge adds K32 on the way out; rc parks at 31 instead of wrapping
                    if (w_last) begin
                        r_c    <= add_round_key(w_round, w_key_nxt);
                        r_done <= 1'b1;
                    end else begin
                        r_rc   <= r_rc + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_c    = r_c;
    assign o_busy = (r_fsm == S_RUN);
    assign o_done = r_done;

endmodule

// File: tb/tb_present80_encrypt_core.sv
// Self-checking bench for present80_encrypt_core: known vectors, protocol
// corner cases and random operands against a behavioural PRESENT-80 model.
module tb_present80_encrypt_core;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] m     = '0;
    logic [79:0] k     = '0;
    logic [63:0] c;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    int SB[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    always #5 clk = ~clk;

    present80_encrypt_core dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_m     (m),
        .i_k     (k),
        .o_c     (c),
        .o_busy  (busy),
        .o_done  (done)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] kr;
        logic [4:0]  rcv;
        s  = pt;
        kr = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kr[79:16];
            for (int j = 0; j < 16; j++) t[4*j +: 4] = 4'(SB[s[4*j +: 4]]);
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
            kr        = {kr[18:0], kr[79:19]};
            kr[79:76] = 4'(SB[kr[79:76]]);
            rcv       = 5'(r);
            kr[19:15] = kr[19:15] ^ rcv;
        end
        return s ^ kr[79:16];
    endfunction

    task automatic launch(input logic [63:0] pm, input logic [79:0] pk);
        @(negedge clk);
        start = 1'b1;
        m     = pm;
        k     = pk;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accept edge until done, optionally hammering start/m/k
    task automatic wait_done(input bit disturb, output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            if (disturb) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                m     = {$urandom, $urandom};
                k     = 80'({$urandom, $urandom, $urandom});
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
    endtask

    task automatic quiet(input int n, input logic [63:0] exp_c, input string tag);
        int d = 0;
        int b = 0;
        int bad_c = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) d++;
            if (busy) b++;
            if (c !== exp_c) bad_c++;
        end
        chk({tag, "_extra_done"}, 80'(d), 80'(0));
        chk({tag, "_idle_busy"},  80'(b), 80'(0));
        chk({tag, "_c_held"},     80'(bad_c), 80'(0));
    endtask

    task automatic run_check(input logic [63:0] pm, input logic [79:0] pk,
                             input logic [63:0] exp, input bit disturb, input string tag);
        int lat;
        int bcnt;
        launch(pm, pk);
        wait_done(disturb, lat, bcnt);
        chk({tag, "_lat"},  80'(lat), 80'(31));
        chk({tag, "_busy"}, 80'(bcnt), 80'(31));
        chk({tag, "_c"},    80'(c), 80'(exp));
        quiet(3, exp, tag);
    endtask

    initial begin
        logic [63:0] ma, mb, exp_a, exp_b;
        logic [79:0] ka, kb;
        int lat, bcnt;

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        m     = 64'h0123_4567_89AB_CDEF;
        k     = 80'h1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_c",    80'(c),    80'(0));
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 80'(busy), 80'(0));

        // Published vectors
        run_check(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, "v00");
        run_check(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, "v0f");
        run_check({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, "vf0");
        run_check({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, "vff");

        // start/m/k toggling during busy must not disturb the running block
        run_check(64'h0, 80'h0, 64'h5579C1387B228445, 1'b1, "hold");
        ma = {$urandom, $urandom};
        ka = 80'({$urandom, $urandom, $urandom});
        run_check(ma, ka, ref_enc(ma, ka), 1'b1, "hold_rnd");

        // Back-to-back: second start in the done cycle
        ma = {$urandom, $urandom};
        ka = 80'({$urandom, $urandom, $urandom});
        mb = {$urandom, $urandom};
        kb = 80'({$urandom, $urandom, $urandom});
        exp_a = ref_enc(ma, ka);
        exp_b = ref_enc(mb, kb);
        launch(ma, ka);
        wait_done(1'b0, lat, bcnt);
        chk("b2b_a_lat", 80'(lat), 80'(31));
        chk("b2b_a_c",   80'(c),   80'(exp_a));
        start = 1'b1;
        m     = mb;
        k     = kb;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done_clr", 80'(done), 80'(0));
        chk("b2b_busy",     80'(busy), 80'(1));
        chk("b2b_c_hold",   80'(c),    80'(exp_a));
        wait_done(1'b0, lat, bcnt);
        chk("b2b_b_lat", 80'(lat), 80'(31));
        chk("b2b_b_c",   80'(c),   80'(exp_b));
        quiet(2, exp_b, "b2b");

        // Reset in the middle of an encryption
        launch(64'h0, 80'h0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_done", 80'(done), 80'(0));
        chk("mid_rst_c",    80'(c),    80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        quiet(40, 64'h0, "mid_rst");
        run_check(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, "after_rst");

        // Random operands against the model
        for (int n = 0; n < 8; n++) begin
            ma = {$urandom, $urandom};
            ka = 80'({$urandom, $urandom, $urandom});
            run_check(ma, ka, ref_enc(ma, ka), 1'b0, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/present80_encrypt_core.md
Name: present80_encrypt_core

Overview:
- Iterative PRESENT-80 block-cipher encryption engine.
- Takes a 64-bit plaintext and an 80-bit key, performs one cipher round per clock over 31 rounds, then applies the final whitening key.
- Sits behind a simple start/done handshake.
- Internally composes three combinational pieces: round function, key-schedule step and final key addition.

Parameters:
- N_B, 64, block width in bits.
- N_K, 80, key width in bits.
- N_R, 32, round-key count; 31 full rounds plus the final key addition.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled on the rising clk edge when idle.
- m  in  64  plaintext; sampled with start.
- k  in  80  key; sampled with start.
- c  out  64  ciphertext; registered, held until the next completion.
- busy  out  1  high while rounds are in progress.
- done  out  1  one-cycle pulse when c is updated.

Behaviour:
- Reset (rst_n=0 at a clk edge): busy=0, done=0, c=0, state=0, key reg=0, round counter rc=0. Reset overrides everything, including mid-operation; any in-flight encryption is discarded.
- Idle accept: at a clk edge with busy=0 and start=1:
  - state<=m, keyreg<=k, rc<=1, busy<=1, done<=0.
- Start while busy=1 is ignored; m and k are not resampled.
- Round edge: at each clk edge with busy=1:
  - state<=round(state, keyreg[79:16])
  - keyreg<=key_schedule(keyreg, rc)
  - rc<=rc+1
- Round function round(s,rk):
  - t = s XOR rk.
  - Apply the 4-bit S-box to each of the 16 nibbles. S-box for inputs 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - Bit permutation: bit i moves to (16*i) mod 63 for i<63; bit 63 stays at 63.
- Key schedule key_schedule(K, rc):
  - K rotated left by 61 bits.
  - Then bits [79:76] replaced by S-box of those bits.
  - Then bits [19:15] XORed with the 5-bit rc.
- Final edge: at the edge where rc==31 (round 31 applied), c<=round(state, keyreg[79:16]) XOR key_schedule(keyreg,31)[79:16]. This is the key addition with K32. On the same edge busy<=0 and done<=1.
- done is high for exactly one cycle. On the next edge done<=0, unless reset intervenes.
- A new start is accepted on the edge after busy falls, i.e. the cycle done is high. That edge both clears done and loads the new operands.
- Latency: start sampled at edge E0; rounds occur at E1..E31; done and c are valid in the cycle after E31.
- Throughput: one block per 32 clocks.
- rc is 5 bits and never wraps in normal operation (maximum 31).
- c changes only at a final edge or on reset.
- Arithmetic: all XORs are bitwise. The rotation is a pure rewire.

Decomposition:
- Shared package present_pkg holds:
  - N_B, N_K, N_R.
  - The 16-entry S-box constant.
  - A permutation function or index function (16*i mod 63).
  - Key-schedule and key-addition helper functions.
- One natural sub-module: present_round_comb, the combinational round (S-box layer plus permutation), instantiated once in the datapath.
- Key schedule and final key addition stay as package functions.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, c=0; no operation starts.
- Vector m=0000000000000000, k=0 -> done exactly 32 edges after start (31 round edges after E0), c=5579C1387B228445, busy high for 31 cycles.
- Vectors:
  - m=0, k=FFFFFFFFFFFFFFFFFFFF -> c=E72C46C0F5945049.
  - m=FFFFFFFFFFFFFFFF, k=0 -> c=A112FFC72F68417B.
  - m=FFFF...FF, k=FFFF...FF -> c=3333DCD3213210D2.
- Start held high or re-pulsed during busy with different m,k -> ignored; the first vector's c is produced, done pulses once.
- Back-to-back: second start in the done cycle -> second result 32 edges later; c holds the first result until then.
- Mid-operation reset: assert rst_n=0 at round 15 -> busy=0, c=0, no done pulse. A fresh start afterwards produces the correct vector.
